// File: rtl/hedios_serial_pkg.sv
// hedios_serial_pkg
// Shared definitions for the HEDIOS serial link (TX and RX sides).
// A HEDIOS packet is five bytes on the wire: the command byte first, then
// the 32-bit data word, least significant byte first.
// Contents:
//   - packet geometry (length, field widths, byte positions)
//   - bit receiver state encoding
//   - clks_per_bit() helper to derive the bit period from clock and baud rate

package hedios_serial_pkg;

    localparam int PACKET_LEN   = 5;
    localparam int BYTE_WIDTH   = 8;
    localparam int CMD_WIDTH    = 8;
    localparam int DATA_WIDTH   = 32;

    // Byte positions within a packet, in wire order
    localparam int CMD_BYTE_IDX = 0;
    localparam int DATA_LSB_IDX = 1;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Integer division on purpose: the bit period is rounded down, and the
    // half-bit sample point tolerates the resulting small rate error.
    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/hedios_serial_rx_if.sv
// hedios_serial_rx_if
// Groups the serial line input and the packet-level outputs of the HEDIOS
// receiver.
//   rx_line        serial input, idle high
//   packet_command command byte of the last complete packet
//   packet_data    data word of the last complete packet
//   packet_valid   one-cycle strobe, packet_* updated this cycle
//   frame_error    one-cycle strobe, stop bit sampled low
//   timeout_error  one-cycle strobe, partial packet dropped on an idle gap
//   busy           packet partially received or byte in flight
// Modports: master = the receiver, slave = the line driver / packet consumer.

interface hedios_serial_rx_if;
    import hedios_serial_pkg::*;

    logic                  rx_line;
    logic [CMD_WIDTH-1:0]  packet_command;
    logic [DATA_WIDTH-1:0] packet_data;
    logic                  packet_valid;
    logic                  frame_error;
    logic                  timeout_error;
    logic                  busy;

    modport master (
        input  rx_line,
        output packet_command,
        output packet_data,
        output packet_valid,
        output frame_error,
        output timeout_error,
        output busy
    );

    modport slave (
        output rx_line,
        input  packet_command,
        input  packet_data,
        input  packet_valid,
        input  frame_error,
        input  timeout_error,
        input  busy
    );

endinterface

// File: rtl/hedios_serial_rx_serial_rx.sv
// serial_rx
// 8N1 bit receiver: two-flop synchroniser followed by the IDLE/START/DATA/STOP
// state machine. Bits are sampled in the middle of each bit period.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx_async     raw serial line, idle high
//   rx_byte      last assembled byte, valid while byte_valid is high
//   byte_valid   one-cycle strobe, byte received with a good stop bit
//   byte_error   one-cycle strobe, stop bit sampled low
//   active       a start bit has been confirmed and the byte is in flight

module serial_rx
    import hedios_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_async,
    output logic [BYTE_WIDTH-1:0] rx_byte,
    output logic                  byte_valid,
    output logic                  byte_error,
    output logic                  active
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    // The synchroniser resets low so that a line held low out of reset never
    // looks like an idle-high line; the receiver arms only on a real high.
    logic [1:0]            sync_q, sync_d;
    logic                  line;
    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [BYTE_WIDTH-1:0] shift_q, shift_d;
    logic                  armed_q, armed_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  byte_error_q, byte_error_d;

    assign line = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= 2'b00;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            armed_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_error_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            armed_q      <= armed_d;
            byte_valid_q <= byte_valid_d;
            byte_error_q <= byte_error_d;
        end
    end

    always_comb begin
        sync_d       = {sync_q[0], rx_async};
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        armed_d      = armed_q | line;
        byte_valid_d = 1'b0;
        byte_error_d = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (armed_q && !line) begin
                    state_d = RX_START;
                end
            end

            // A start bit that is gone by mid-bit was a glitch; drop it quietly.
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    shift_d   = {line, shift_q[BYTE_WIDTH-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Leave at mid stop bit so a back-to-back start edge is never missed.
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (line) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        byte_error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = RX_IDLE;
        endcase
    end

    // shift_q is untouched until the next byte's first data sample, so it is
    // stable while the registered byte_valid strobe is high.
    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign byte_error = byte_error_q;
    assign active     = (state_q == RX_DATA) || (state_q == RX_STOP);

endmodule

// File: rtl/hedios_serial_rx.sv
// hedios_serial_rx
// HEDIOS packet receiver: bit receiver plus packet assembler. Collects five
// bytes (command, then data LSB first) and presents each complete packet
// with a one-cycle packet_valid strobe. A bad stop bit or an idle gap longer
// than TIMEOUT_BITS bit periods inside a packet discards the partial packet.
// Parameters:
//   CLK_RATE      clk frequency in Hz
//   BAUD_RATE     line bit rate; CLK_RATE/BAUD_RATE must be at least 8
//   TIMEOUT_BITS  maximum idle gap between bytes of one packet, in bit periods
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   bus           hedios_serial_rx_if.master (rx_line in, packet/strobe outputs)

module hedios_serial_rx
    import hedios_serial_pkg::*;
#(
    parameter int CLK_RATE     = 100_000_000,
    parameter int BAUD_RATE    = 1_000_000,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               clk,
    input  logic               rst,
    hedios_serial_rx_if.master bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
    localparam int IDX_W        = $clog2(PACKET_LEN);
    localparam int PKT_W        = PACKET_LEN * BYTE_WIDTH;

    logic [BYTE_WIDTH-1:0] rx_byte;
    logic                  byte_valid;
    logic                  byte_error;
    logic                  rx_active;

    serial_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serial_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_async  (bus.rx_line),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_error(byte_error),
        .active    (rx_active)
    );

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PKT_W-1:0]      asm_q, asm_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  packet_valid_q, packet_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  timeout_error_q, timeout_error_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q           <= '0;
            asm_q           <= '0;
            to_cnt_q        <= '0;
            cmd_q           <= '0;
            data_q          <= '0;
            packet_valid_q  <= 1'b0;
            frame_error_q   <= 1'b0;
            timeout_error_q <= 1'b0;
        end else begin
            idx_q           <= idx_d;
            asm_q           <= asm_d;
            to_cnt_q        <= to_cnt_d;
            cmd_q           <= cmd_d;
            data_q          <= data_d;
            packet_valid_q  <= packet_valid_d;
            frame_error_q   <= frame_error_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    // The if/else chain gives byte_valid priority over byte_error and over
    // timeout expiry, which keeps the three strobes mutually exclusive.
    // to_cnt counts clocks since the last byte_valid, including that cycle,
    // so the error strobe lands exactly TIMEOUT_CLKS after it.
    always_comb begin
        idx_d           = idx_q;
        asm_d           = asm_q;
        to_cnt_d        = to_cnt_q;
        cmd_d           = cmd_q;
        data_d          = data_q;
        packet_valid_d  = 1'b0;
        frame_error_d   = 1'b0;
        timeout_error_d = 1'b0;

        if (byte_valid) begin
            asm_d[{idx_q, 3'b000} +: BYTE_WIDTH] = rx_byte;
            to_cnt_d = TO_W'(1);
            if (idx_q == IDX_W'(PACKET_LEN - 1)) begin
                cmd_d          = asm_d[CMD_BYTE_IDX*BYTE_WIDTH +: CMD_WIDTH];
                data_d         = asm_d[DATA_LSB_IDX*BYTE_WIDTH +: DATA_WIDTH];
                packet_valid_d = 1'b1;
                idx_d          = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (byte_error) begin
            frame_error_d = 1'b1;
            idx_d         = '0;
            to_cnt_d      = '0;
        end else if (idx_q != '0 && !rx_active) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
                timeout_error_d = 1'b1;
                idx_d           = '0;
                to_cnt_d        = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else if (idx_q == '0) begin
            to_cnt_d = '0;
        end
    end

    assign bus.packet_command = cmd_q;
    assign bus.packet_data    = data_q;
    assign bus.packet_valid   = packet_valid_q;
    assign bus.frame_error    = frame_error_q;
    assign bus.timeout_error  = timeout_error_q;
    assign bus.busy           = (idx_q != '0) || rx_active;

endmodule

// File: tb/tb_hedios_serial_rx.sv
// tb_hedios_serial_rx
// Directed bench for hedios_serial_rx at the default rates (100 clk per bit,
// timeout 2000 clk). Frames are driven on the falling edge; outputs and
// strobes are observed on the falling edge.
//
// Expected strobe timing, counted in rising edges from the one just before a
// start bit is driven: 2 synchroniser + 1 edge detect + 50 half bit
// + 8*100 data + 100 stop = 953 for byte_valid, 954 for packet_valid,
// and byte_valid + 2000 = 2953 for timeout_error.

module tb_hedios_serial_rx;
    import hedios_serial_pkg::*;

    localparam int CPB = 100;

    logic clk = 1'b0;
    logic rst;

    hedios_serial_rx_if bus();

    hedios_serial_rx #(
        .CLK_RATE    (100_000_000),
        .BAUD_RATE   (1_000_000),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Strobe monitor
    int          pv_count   = 0;
    int          fe_count   = 0;
    int          te_count   = 0;
    int          te_last    = -1;
    int          excl_viol  = 0;
    bit          busy_seen  = 1'b0;
    int          pv_cycle[$];
    logic [7:0]  pv_cmd[$];
    logic [31:0] pv_data[$];

    always @(negedge clk) begin
        if (bus.packet_valid) begin
            pv_count++;
            pv_cycle.push_back(cycle);
            pv_cmd.push_back(bus.packet_command);
            pv_data.push_back(bus.packet_data);
        end
        if (bus.frame_error) fe_count++;
        if (bus.timeout_error) begin
            te_count++;
            te_last = cycle;
        end
        if ((int'(bus.packet_valid) + int'(bus.frame_error) + int'(bus.timeout_error)) > 1)
            excl_viol++;
        if (bus.busy) busy_seen = 1'b1;
    end

    int compared   = 0;
    int mismatched = 0;
    int last_start = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame; starts and ends on a falling edge so consecutive
    // calls produce back-to-back frames exactly 10 bit periods apart.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        bus.rx_line = 1'b0;
        last_start  = cycle;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            bus.rx_line = b[i];
        end
        repeat (CPB) @(negedge clk);
        bus.rx_line = stop_bit;
        repeat (CPB) @(negedge clk);
        bus.rx_line = 1'b1;
    endtask

    task automatic sendPacket(input logic [7:0] cmd, input logic [31:0] data);
        applyStimulus(cmd, 1'b1);
        applyStimulus(data[7:0], 1'b1);
        applyStimulus(data[15:8], 1'b1);
        applyStimulus(data[23:16], 1'b1);
        applyStimulus(data[31:24], 1'b1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int s2;
    int pv_before, fe_before, te_before;

    initial begin
        bus.rx_line = 1'b0;
        rst         = 1'b1;
        idleCycles(4);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_cmd",  bus.packet_command, 64'h0);
        checkOutput("reset_data", bus.packet_data,    64'h0);
        checkOutput("reset_pv",   bus.packet_valid,   64'h0);
        checkOutput("reset_fe",   bus.frame_error,    64'h0);
        checkOutput("reset_te",   bus.timeout_error,  64'h0);
        checkOutput("reset_busy", bus.busy,           64'h0);

        // Line held low out of reset must not be taken as a start bit
        busy_seen = 1'b0;
        idleCycles(300);
        checkOutput("low_from_reset_fe",   fe_count,  64'd0);
        checkOutput("low_from_reset_busy", busy_seen, 64'd0);
        bus.rx_line = 1'b1;
        idleCycles(50);

        // Basic packet
        $display("[TB] packet A5/12345678");
        sendPacket(8'hA5, 32'h12345678);
        idleCycles(20);
        checkOutput("p1_count", pv_count, 64'd1);
        checkOutput("p1_cmd",   bus.packet_command, 64'hA5);
        checkOutput("p1_data",  bus.packet_data,    64'h12345678);
        checkOutput("p1_busy",  bus.busy,           64'h0);
        checkOutput("p1_time",  pv_cycle[0], 64'(last_start + 954));

        // Short low glitch on an idle line
        $display("[TB] 30-cycle glitch");
        busy_seen   = 1'b0;
        bus.rx_line = 1'b0;
        idleCycles(30);
        bus.rx_line = 1'b1;
        idleCycles(300);
        checkOutput("glitch_pv",   pv_count,  64'd1);
        checkOutput("glitch_fe",   fe_count,  64'd0);
        checkOutput("glitch_busy", busy_seen, 64'd0);

        // Bad stop bit on the third byte
        $display("[TB] framing error on byte 3");
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b0);
        idleCycles(300);
        checkOutput("fe_count",    fe_count, 64'd1);
        checkOutput("fe_no_pv",    pv_count, 64'd1);
        checkOutput("fe_cmd_hold", bus.packet_command, 64'hA5);
        checkOutput("fe_busy",     bus.busy, 64'h0);
        sendPacket(8'h01, 32'hDEADBEEF);
        idleCycles(20);
        checkOutput("p2_count", pv_count, 64'd2);
        checkOutput("p2_cmd",   bus.packet_command, 64'h01);
        checkOutput("p2_data",  bus.packet_data,    64'hDEADBEEF);

        // Inter-byte timeout
        $display("[TB] timeout after two bytes");
        applyStimulus(8'h44, 1'b1);
        applyStimulus(8'h55, 1'b1);
        s2 = last_start;
        idleCycles(2500);
        checkOutput("to_count", te_count, 64'd1);
        checkOutput("to_time",  te_last,  64'(s2 + 2953));
        checkOutput("to_no_pv", pv_count, 64'd2);
        checkOutput("to_busy",  bus.busy, 64'h0);
        sendPacket(8'h02, 32'h00000001);
        idleCycles(20);
        checkOutput("p3_count", pv_count, 64'd3);
        checkOutput("p3_cmd",   bus.packet_command, 64'h02);
        checkOutput("p3_data",  bus.packet_data,    64'h00000001);

        // Two packets with no idle time between frames
        $display("[TB] back-to-back packets");
        sendPacket(8'hC3, 32'h89ABCDEF);
        sendPacket(8'h3C, 32'h76543210);
        idleCycles(20);
        checkOutput("b2b_count", pv_count, 64'd5);
        if (pv_count == 5) begin
            checkOutput("b2b_gap",   pv_cycle[4] - pv_cycle[3], 64'd5000);
            checkOutput("b2b_cmd0",  pv_cmd[3],  64'hC3);
            checkOutput("b2b_data0", pv_data[3], 64'h89ABCDEF);
        end
        checkOutput("b2b_cmd1",  bus.packet_command, 64'h3C);
        checkOutput("b2b_data1", bus.packet_data,    64'h76543210);
        checkOutput("b2b_te",    te_count, 64'd1);

        // Reset in the middle of the third byte
        $display("[TB] reset mid-packet");
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        bus.rx_line = 1'b0;
        idleCycles(350);
        rst         = 1'b1;
        bus.rx_line = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        pv_before = pv_count;
        fe_before = fe_count;
        te_before = te_count;
        idleCycles(3);
        checkOutput("rst_cmd",  bus.packet_command, 64'h0);
        checkOutput("rst_data", bus.packet_data,    64'h0);
        checkOutput("rst_busy", bus.busy,           64'h0);
        idleCycles(3000);
        checkOutput("rst_no_pv", pv_count, 64'(pv_before));
        checkOutput("rst_no_fe", fe_count, 64'(fe_before));
        checkOutput("rst_no_te", te_count, 64'(te_before));
        sendPacket(8'h7F, 32'hCAFEF00D);
        idleCycles(20);
        checkOutput("p4_count", pv_count, 64'(pv_before + 1));
        checkOutput("p4_cmd",   bus.packet_command, 64'h7F);
        checkOutput("p4_data",  bus.packet_data,    64'hCAFEF00D);

        checkOutput("strobe_exclusive", excl_viol, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
